data_memory: RTL and testbench

Single-cycle data memory for the RV32I datapath, sitting after the ALU in the MEM stage. It holds 16 words of 32 bits, performs synchronous stores of byte, halfword or word width, and returns combinational loads with sign or zero extension selected by `mem_type`, which uses RISC-V funct3 encoding.

---
 rtl/data_memory.sv | 66 ++++++
 tb/tb_data_memory.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// 16x32 RV32I data memory: byte/halfword/word stores, sign- or zero-extended loads by funct3.
// Latency: stores commit on the rising clk edge; loads are combinational (zero cycles).
// Backpressure: none; every request completes in the cycle it is presented.
module data_memory (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [2:0]  mem_type,
    input  logic        read_enable,
    output logic [31:0] read_data
);

    logic [31:0] mem_q [16];
    logic [31:0] mem_d [16];
    logic [31:0] wr_mask;
    logic [31:0] rd_word;

    // A byte-lane mask keeps untouched lanes intact on sub-word stores.
    always_comb begin
        wr_mask = '0;
        if (write_enable) begin
            case (mem_type)
                3'b000, 3'b100: wr_mask = 32'h0000_00FF;
                3'b001, 3'b101: wr_mask = 32'h0000_FFFF;
                3'b010:         wr_mask = 32'hFFFF_FFFF;
                default:        wr_mask = '0;
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            mem_d[i] = mem_q[i];
            if (address == 4'(i)) begin
                mem_d[i] = (mem_q[i] & ~wr_mask) | (write_data & wr_mask);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        rd_word   = mem_q[address];
        read_data = '0;
        if (read_enable) begin
            case (mem_type)
                3'b000:  read_data = {{24{rd_word[7]}}, rd_word[7:0]};
                3'b001:  read_data = {{16{rd_word[15]}}, rd_word[15:0]};
                3'b010:  read_data = rd_word;
                3'b100:  read_data = {24'h0, rd_word[7:0]};
                3'b101:  read_data = {16'h0, rd_word[15:0]};
                default: read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: vector table plus reset, same-cycle and sweep sequences.
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic [3:0]  address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [2:0]  mem_type;
    logic        read_enable;
    logic [31:0] read_data;

    int total;
    int bad;

    typedef struct {
        string       name;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  mt;
        logic        re;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

    data_memory dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .mem_type     (mem_type),
        .read_enable  (read_enable),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    task automatic store(input logic [3:0] a, input logic [31:0] d, input logic [2:0] mt);
        @(negedge clk);
        address      = a;
        write_data   = d;
        mem_type     = mt;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic load_check(input string name, input logic [3:0] a, input logic [2:0] mt,
                              input logic [31:0] exp);
        @(negedge clk);
        address      = a;
        mem_type     = mt;
        read_enable  = 1'b1;
        write_enable = 1'b0;
        #1;
        check(name, read_data, exp);
    endtask

    function automatic logic [31:0] sweep_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        address      = '0;
        write_data   = '0;
        write_enable = 1'b0;
        mem_type     = 3'b010;
        read_enable  = 1'b1;

        // Reset state: every read shows zero while reset is low.
        #2;
        check("rst_word_a0", read_data, 32'h0);
        address  = 4'd5;  mem_type = 3'b000; #1;
        check("rst_byte_a5", read_data, 32'h0);
        address  = 4'd15; mem_type = 3'b101; #1;
        check("rst_half_a15", read_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        vq.push_back('{"st_byte_a0",      4'd0, 32'h0000_0006, 1'b1, 3'b000, 1'b1, 32'h0000_0006});
        vq.push_back('{"ld_byte_a0",      4'd0, 32'h0,         1'b0, 3'b000, 1'b1, 32'h0000_0006});
        vq.push_back('{"st_byte_a1",      4'd1, 32'h0000_00F0, 1'b1, 3'b000, 1'b1, 32'hFFFF_FFF0});
        vq.push_back('{"ld_ubyte_a1",     4'd1, 32'h0,         1'b0, 3'b100, 1'b1, 32'h0000_00F0});
        vq.push_back('{"ld_word_a1",      4'd1, 32'h0,         1'b0, 3'b010, 1'b1, 32'h0000_00F0});
        vq.push_back('{"st_byte_hi_ign",  4'd2, 32'hFFFF_FF55, 1'b1, 3'b000, 1'b1, 32'h0000_0055});
        vq.push_back('{"ld_word_a2",      4'd2, 32'h0,         1'b0, 3'b010, 1'b1, 32'h0000_0055});
        vq.push_back('{"st_word_a3",      4'd3, 32'h1234_5678, 1'b1, 3'b010, 1'b1, 32'h1234_5678});
        vq.push_back('{"st_byte_a3",      4'd3, 32'h0000_00AB, 1'b1, 3'b000, 1'b1, 32'hFFFF_FFAB});
        vq.push_back('{"lane_after_byte", 4'd3, 32'h0,         1'b0, 3'b010, 1'b1, 32'h1234_56AB});
        vq.push_back('{"st_half_a3",      4'd3, 32'h0000_CDEF, 1'b1, 3'b001, 1'b1, 32'hFFFF_CDEF});
        vq.push_back('{"lane_after_half", 4'd3, 32'h0,         1'b0, 3'b010, 1'b1, 32'h1234_CDEF});
        vq.push_back('{"st_ubyte_a3",     4'd3, 32'h7777_7799, 1'b1, 3'b100, 1'b1, 32'h0000_0099});
        vq.push_back('{"lane_after_ub",   4'd3, 32'h0,         1'b0, 3'b010, 1'b1, 32'h1234_CD99});
        vq.push_back('{"st_uhalf_a4",     4'd4, 32'hAAAA_9876, 1'b1, 3'b101, 1'b1, 32'h0000_9876});
        vq.push_back('{"ld_word_a4",      4'd4, 32'h0,         1'b0, 3'b010, 1'b1, 32'h0000_9876});
        vq.push_back('{"st_word_a7",      4'd7, 32'h0000_8001, 1'b1, 3'b010, 1'b1, 32'h0000_8001});
        vq.push_back('{"ld_shalf_a7",     4'd7, 32'h0,         1'b0, 3'b001, 1'b1, 32'hFFFF_8001});
        vq.push_back('{"ld_uhalf_a7",     4'd7, 32'h0,         1'b0, 3'b101, 1'b1, 32'h0000_8001});
        vq.push_back('{"we0_x_data",      4'd0, 32'hxxxx_xxxx, 1'b0, 3'b010, 1'b1, 32'h0000_0006});
        vq.push_back('{"st_type011",      4'd0, 32'hFFFF_FFFF, 1'b1, 3'b011, 1'b1, 32'h0000_0000});
        vq.push_back('{"after_type011",   4'd0, 32'h0,         1'b0, 3'b010, 1'b1, 32'h0000_0006});
        vq.push_back('{"st_type111",      4'd7, 32'hFFFF_FFFF, 1'b1, 3'b111, 1'b0, 32'h0000_0000});
        vq.push_back('{"after_type111",   4'd7, 32'h0,         1'b0, 3'b010, 1'b1, 32'h0000_8001});
        vq.push_back('{"re0_word",        4'd3, 32'h0,         1'b0, 3'b010, 1'b0, 32'h0000_0000});
        vq.push_back('{"ld_type011",      4'd3, 32'h0,         1'b0, 3'b011, 1'b1, 32'h0000_0000});
        vq.push_back('{"ld_type110",      4'd3, 32'h0,         1'b0, 3'b110, 1'b1, 32'h0000_0000});
        vq.push_back('{"ld_type111",      4'd3, 32'h0,         1'b0, 3'b111, 1'b1, 32'h0000_0000});

        foreach (vq[k]) begin
            @(negedge clk);
            address      = vq[k].addr;
            write_data   = vq[k].wdata;
            write_enable = vq[k].we;
            mem_type     = vq[k].mt;
            read_enable  = vq[k].re;
            @(posedge clk);
            #1;
            check(vq[k].name, read_data, vq[k].exp);
        end
        write_enable = 1'b0;
        write_data   = '0;

        // Same-cycle read and write: old value before the edge, new after.
        store(4'd15, 32'h1111_1111, 3'b010);
        @(negedge clk);
        address      = 4'd15;
        write_data   = 32'h2222_2222;
        mem_type     = 3'b010;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        #1;
        check("rdwr_before_edge", read_data, 32'h1111_1111);
        @(posedge clk);
        #1;
        check("rdwr_after_edge", read_data, 32'h2222_2222);
        write_enable = 1'b0;

        // Address sweep: distinct words, then read all back.
        for (int i = 0; i < 16; i++) store(4'(i), sweep_word(i), 3'b010);
        for (int i = 0; i < 16; i++) load_check($sformatf("sweep_a%0d", i), 4'(i), 3'b010, sweep_word(i));

        // Short asynchronous reset pulse between edges.
        store(4'd5, 32'hDEAD_BEEF, 3'b010);
        load_check("pre_pulse_a5", 4'd5, 3'b010, 32'hDEAD_BEEF);
        #1;
        reset = 1'b0;
        #1;
        check("pulse_during_a5", read_data, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("pulse_after_a5", read_data, 32'h0);
        load_check("pulse_after_a15", 4'd15, 3'b010, 32'h0);

        // A store presented while reset is held across an edge is lost.
        @(negedge clk);
        reset        = 1'b0;
        address      = 4'd9;
        write_data   = 32'h5555_5555;
        mem_type     = 3'b010;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        check("store_in_reset", read_data, 32'h0);
        @(negedge clk);
        reset        = 1'b1;
        write_enable = 1'b0;
        #1;
        check("store_in_reset_rel", read_data, 32'h0);

        // First edge after release captures the store.
        write_data   = 32'h0BAD_F00D;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        check("first_store_post_rst", read_data, 32'h0BAD_F00D);
        write_enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
